// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
//   8N1 serial receive front end with 16x oversampling. The rx pin is
//   synchronised through two flops. Each bit is decided by a 3-sample majority
//   vote taken at oversample ticks 7, 8 and 9 of the bit period. One received
//   byte is held, together with its status flags, until the CPU acknowledges it.
//
//   Parameters:
//     BAUD_DIV   clk cycles per oversample tick
//     DATA_BITS  data bits per frame (LSB first, no parity, 1 stop bit)
//   Ports:
//     clk        system clock, rising edge
//     reset      synchronous, active-high
//     rx         asynchronous serial input, idle high
//     rd_ack     1-cycle pulse: CPU has read rx_data; clears the flags
//     rx_data    last received byte
//     rx_valid   rx_data holds an unread byte
//     frame_err  stop bit of the last stored frame was sampled low
//     overrun    a byte was stored while an unread byte was pending
//     rx_irq     1-cycle pulse when a frame is stored
module uart_rx_frontend #(
    parameter int unsigned BAUD_DIV  = 325,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_irq
);

    localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_n;

    logic                 rx_meta, rx_s;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           tick_idx;
    logic                 tick, mid, end_bit;
    logic                 samp7, samp8, majority;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;

    // FSM outputs
    logic align, bit_clr, bit_inc, shift_en, store;

    assign tick     = (div_cnt == DIV_W'(BAUD_DIV - 1));
    assign mid      = tick && (tick_idx == 4'd9);
    assign end_bit  = tick && (tick_idx == 4'd15);
    // Third vote is the live sample at tick 9
    assign majority = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        align    = 1'b0;
        bit_clr  = 1'b0;
        bit_inc  = 1'b0;
        shift_en = 1'b0;
        store    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    align   = 1'b1;
                end
            end
            S_START: begin
                if (mid) begin
                    if (majority) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DATA;
                        bit_clr = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_en = 1'b1;
                end
                // DATA is entered mid start bit, so the first tick 15 seen here
                // closes the start bit; bit_cnt therefore reaches DATA_BITS at
                // the end of the second-to-last data bit.
                if (end_bit) begin
                    if (bit_cnt == CNT_W'(DATA_BITS)) begin
                        state_n = S_STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (mid) begin
                    store   = 1'b1;
                    state_n = majority ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            div_cnt   <= '0;
            tick_idx  <= '0;
            samp7     <= 1'b1;
            samp8     <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_irq    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            // Realign the oversample grid to the detected start edge
            if (align) begin
                div_cnt  <= '0;
                tick_idx <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_idx <= tick_idx + 4'd1;
            end else begin
                div_cnt  <= div_cnt + 1'b1;
            end

            if (tick && (tick_idx == 4'd7)) begin
                samp7 <= rx_s;
            end
            if (tick && (tick_idx == 4'd8)) begin
                samp8 <= rx_s;
            end

            if (shift_en) begin
                shreg <= {majority, shreg[DATA_BITS-1:1]};
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            rx_irq <= store;
            if (store) begin
                rx_data   <= shreg;
                rx_valid  <= 1'b1;
                frame_err <= ~majority;
                // A simultaneous ack consumed the old byte, so no overrun
                if (rx_valid && !rd_ack) begin
                    overrun <= 1'b1;
                end
            end else if (rd_ack) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend
//   Directed bench for uart_rx_frontend with BAUD_DIV=4 (64 clk per bit).
//   Expected frames are queued when sent and checked when rx_irq fires.
module tb_uart_rx_frontend;

    localparam int unsigned BIT_CLKS = 64;

    typedef struct packed {
        logic       ferr;
        logic       ovr;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_irq;

    int   compared   = 0;
    int   mismatched = 0;
    int   irq_count  = 0;
    int   irq0;
    exp_t exp_q[$];

    uart_rx_frontend #(
        .BAUD_DIV (4),
        .DATA_BITS(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd_ack   (rd_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_irq   (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx_irq pulse consumes one expected frame
    always @(negedge clk) begin
        if (rx_irq === 1'b1) begin
            exp_t e;
            irq_count++;
            chk("sb_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(rx_data), 32'(e.data));
                chk("sb_frame_err", 32'(frame_err), 32'(e.ferr));
                chk("sb_overrun", 32'(overrun), 32'(e.ovr));
                chk("sb_valid", 32'(rx_valid), 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    // Drives one 8N1 frame starting at the current negedge. glitch_at inverts rx
    // for one clk at that offset; abort_at pulses reset there and ends the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int extra_low, input int glitch_at,
                              input int abort_at);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        for (int c = 0; c < 10 * BIT_CLKS; c++) begin
            if (c == abort_at) begin
                reset = 1'b1;
                rx    = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                return;
            end
            rx = fr[c / BIT_CLKS];
            if (c == glitch_at) rx = ~rx;
            @(negedge clk);
        end
        repeat (extra_low) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic push(input logic ferr, input logic ovr, input logic [7:0] d);
        exp_t e;
        e.ferr = ferr;
        e.ovr  = ovr;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        rx     = 1'b1;
        rd_ack = 1'b0;
        reset  = 1'b1;
        idle(4);
        reset = 1'b0;
        idle(1);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_irq", 32'(rx_irq), 0);

        // Plain frame, then acknowledge
        irq0 = irq_count;
        push(1'b0, 1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1, 0, -1, -1);
        idle(20);
        chk("a5_irq_pulses", 32'(irq_count - irq0), 1);
        chk("a5_valid", 32'(rx_valid), 1);
        chk("a5_data", 32'(rx_data), 32'h A5);
        chk("a5_frame_err", 32'(frame_err), 0);
        ack();
        chk("a5_ack_valid", 32'(rx_valid), 0);

        // Short low pulse is rejected as a false start
        irq0 = irq_count;
        rx   = 1'b0;
        idle(20);
        rx   = 1'b1;
        idle(100);
        chk("glitch_irq", 32'(irq_count - irq0), 0);
        chk("glitch_valid", 32'(rx_valid), 0);

        // Stop bit low followed by a long break
        irq0 = irq_count;
        push(1'b1, 1'b0, 8'h3C);
        send_frame(8'h3C, 1'b0, 200 - BIT_CLKS, -1, -1);
        idle(100);
        chk("brk_irq_pulses", 32'(irq_count - irq0), 1);
        chk("brk_data", 32'(rx_data), 32'h3C);
        chk("brk_frame_err", 32'(frame_err), 1);
        ack();
        irq0 = irq_count;
        push(1'b0, 1'b0, 8'h11);
        send_frame(8'h11, 1'b1, 0, -1, -1);
        idle(20);
        chk("after_brk_irq", 32'(irq_count - irq0), 1);
        chk("after_brk_data", 32'(rx_data), 32'h11);
        chk("after_brk_frame_err", 32'(frame_err), 0);
        ack();

        // Back-to-back frames without acknowledge
        irq0 = irq_count;
        push(1'b0, 1'b0, 8'h01);
        push(1'b0, 1'b1, 8'h02);
        send_frame(8'h01, 1'b1, 0, -1, -1);
        send_frame(8'h02, 1'b1, 0, -1, -1);
        idle(20);
        chk("b2b_irq_pulses", 32'(irq_count - irq0), 2);
        chk("b2b_data", 32'(rx_data), 32'h02);
        chk("b2b_overrun", 32'(overrun), 1);
        chk("b2b_valid", 32'(rx_valid), 1);
        ack();
        chk("b2b_ack_valid", 32'(rx_valid), 0);
        chk("b2b_ack_overrun", 32'(overrun), 0);
        chk("b2b_ack_frame_err", 32'(frame_err), 0);

        // One-clk high glitch on the tick-8 sample of data bit 3
        irq0 = irq_count;
        push(1'b0, 1'b0, 8'h00);
        send_frame(8'h00, 1'b1, 0, 4 * BIT_CLKS + 36, -1);
        idle(20);
        chk("vote_irq", 32'(irq_count - irq0), 1);
        chk("vote_data", 32'(rx_data), 0);
        chk("vote_valid", 32'(rx_valid), 1);

        // Reset in the middle of data bit 4 (unread byte still pending)
        irq0 = irq_count;
        send_frame(8'hFF, 1'b1, 0, -1, 5 * BIT_CLKS + 20);
        chk("midrst_data", 32'(rx_data), 0);
        chk("midrst_valid", 32'(rx_valid), 0);
        chk("midrst_frame_err", 32'(frame_err), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        idle(200);
        chk("midrst_no_store", 32'(irq_count - irq0), 0);
        chk("midrst_still_empty", 32'(rx_valid), 0);
        push(1'b0, 1'b0, 8'h7E);
        send_frame(8'h7E, 1'b1, 0, -1, -1);
        idle(20);
        chk("post_rst_irq", 32'(irq_count - irq0), 1);
        chk("post_rst_data", 32'(rx_data), 32'h7E);
        chk("post_rst_valid", 32'(rx_valid), 1);

        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
